// File: rtl/dsi_tx_line_packer_if.sv
// dsi_tx_line_packer_if
// Packet output stream of the DSI line packer.
//   out_data  [31:0]  packet word, byte 0 in [7:0] goes first on the link
//   out_valid         out_data is valid
//   out_ready         sink accepts the word this cycle
//   out_strb  [3:0]   valid-byte mask
//   out_sop/out_eop   first / last word of a packet
// master: the packer (drives the stream); slave: the sink (drives out_ready).
interface dsi_tx_line_packer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_strb;
  logic        out_sop;
  logic        out_eop;

  modport master (
    output out_data, out_valid, out_strb, out_sop, out_eop,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_strb, out_sop, out_eop,
    output out_ready
  );
endinterface

// File: rtl/dsi_tx_line_packer.sv
// dsi_tx_line_packer
// Wraps one buffered video line into a DSI long packet: 4-byte header
// (DI, WC, ECC), LINE_BYTES/4 payload words popped from a show-ahead FIFO,
// and a footer word carrying the 16-bit checksum in its two valid bytes.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   fifo_data         show-ahead FIFO word (byte 0 in [7:0])
//   fifo_not_empty    fifo_data is valid
//   fifo_line_ready   a complete line is buffered
//   fifo_read_ack     pops one FIFO word this cycle
//   enable            allows a new packet to start (sampled in IDLE only)
//   out_if            packet stream (master modport)
//   busy              FSM is outside IDLE
//   underrun          sticky: FIFO ran dry in the middle of the payload
//
// Build option
//   DSI_TX_CRC_EN     defined: footer carries CRC-16-CCITT of the payload
//                     undefined: no CRC logic, footer checksum is 16'h0000
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for enable and a buffered line; stream quiet
// HEADER  | presenting the packet header word (sop)
// PAYLOAD | forwarding FIFO words, stalling while the FIFO is empty
// FOOTER  | presenting the checksum word (eop)
module dsi_tx_line_packer #(
  parameter int unsigned LINE_BYTES = 640,
  parameter logic [5:0]  DATA_TYPE  = 6'h3E,
  parameter logic [1:0]  VC         = 2'd0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  fifo_data,
  input  logic                         fifo_not_empty,
  input  logic                         fifo_line_ready,
  output logic                         fifo_read_ack,
  input  logic                         enable,
  dsi_tx_line_packer_if.master         out_if,
  output logic                         busy,
  output logic                         underrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    FOOTER  = 2'd3
  } state_t;

  // DSI header ECC: Hamming code over {WC, DI}, D[0] = DI[0].
  function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^{d[0], d[1], d[2], d[4], d[5], d[7], d[10], d[11], d[13],
             d[16], d[20], d[21], d[22], d[23]};
    p[1] = ^{d[0], d[1], d[3], d[4], d[6], d[8], d[10], d[12], d[14],
             d[17], d[20], d[21], d[22], d[23]};
    p[2] = ^{d[0], d[2], d[3], d[5], d[6], d[9], d[11], d[12], d[15],
             d[18], d[20], d[21], d[22]};
    p[3] = ^{d[1], d[2], d[3], d[7], d[8], d[9], d[13], d[14], d[15],
             d[19], d[20], d[21], d[23]};
    p[4] = ^{d[4], d[5], d[6], d[7], d[8], d[9], d[16], d[17], d[18],
             d[19], d[20], d[22], d[23]};
    p[5] = ^{d[10], d[11], d[12], d[13], d[14], d[15], d[16], d[17],
             d[18], d[19], d[21], d[22], d[23]};
    return p;
  endfunction

  localparam logic [15:0] WC          = 16'(LINE_BYTES);
  localparam logic [7:0]  DI          = {VC, DATA_TYPE};
  localparam logic [31:0] HEADER_WORD = {2'b00, dsi_ecc({WC, DI}), WC, DI};
  localparam logic [15:0] LAST_IDX    = 16'(LINE_BYTES / 4 - 1);

  state_t      state_q, state_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        underrun_q, underrun_d;
  logic        pay_accept;
  logic [15:0] footer_crc;

  logic [31:0] out_data_c;
  logic        out_valid_c;
  logic [3:0]  out_strb_c;
  logic        out_sop_c;
  logic        out_eop_c;

  assign pay_accept = (state_q == PAYLOAD) && fifo_not_empty && out_if.out_ready;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    underrun_d  = underrun_q;
    out_data_c  = 32'h0000_0000;
    out_valid_c = 1'b0;
    out_strb_c  = 4'h0;
    out_sop_c   = 1'b0;
    out_eop_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && fifo_line_ready) begin
          state_d    = HEADER;
          underrun_d = 1'b0;
        end
      end

      HEADER: begin
        out_valid_c = 1'b1;
        out_sop_c   = 1'b1;
        out_strb_c  = 4'hF;
        out_data_c  = HEADER_WORD;
        if (out_if.out_ready) begin
          state_d    = PAYLOAD;
          word_cnt_d = 16'd0;
        end
      end

      PAYLOAD: begin
        out_valid_c = fifo_not_empty;
        out_strb_c  = 4'hF;
        out_data_c  = fifo_data;
        if (!fifo_not_empty) begin
          underrun_d = 1'b1;
        end
        if (pay_accept) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_q == LAST_IDX) begin
            state_d = FOOTER;
          end
        end
      end

      FOOTER: begin
        out_valid_c = 1'b1;
        out_eop_c   = 1'b1;
        out_strb_c  = 4'b0011;
        out_data_c  = {16'h0000, footer_crc};
        if (out_if.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= 16'd0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef DSI_TX_CRC_EN
  // Reflected CRC-16-CCITT (0x8408 is 0x1021 bit-reversed), one bit per
  // step, bits 0..31 of the word = bytes 0..3 each LSB first.
  function automatic logic [15:0] crc_word(input logic [15:0] c_in,
                                           input logic [31:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ d[i]) begin
        c = (c >> 1) ^ 16'h8408;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if ((state_q == HEADER) && out_if.out_ready) begin
      crc_d = 16'hFFFF;
    end else if (pay_accept) begin
      crc_d = crc_word(crc_q, fifo_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign footer_crc = crc_q;
`else
  assign footer_crc = 16'h0000;
`endif

  assign fifo_read_ack    = pay_accept;
  assign busy             = (state_q != IDLE);
  assign underrun         = underrun_q;
  assign out_if.out_data  = out_data_c;
  assign out_if.out_valid = out_valid_c;
  assign out_if.out_strb  = out_strb_c;
  assign out_if.out_sop   = out_sop_c;
  assign out_if.out_eop   = out_eop_c;

endmodule

// File: doc/dsi_tx_line_packer.md
DSI_TX_LINE_PACKER -- requirements
Module: dsi_tx_line_packer

Interface
REQ-001 Parameter LINE_BYTES, default 640: payload word count (WC) in bytes; multiple of 4; range 4..65532.
REQ-002 Parameter DATA_TYPE, default 6'h3E: DSI data type placed in DI[5:0].
REQ-003 Parameter VC, default 2'd0: virtual channel placed in DI[7:6].
REQ-004 clk  input  1  clock; one clock domain, the pixel-buffer read side.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 fifo_data  input  32  show-ahead pixel word; byte 0 is [7:0].
REQ-007 fifo_not_empty  input  1  fifo_data is valid.
REQ-008 fifo_line_ready  input  1  at least one full line is buffered.
REQ-009 fifo_read_ack  output  1  pops one FIFO word this cycle.
REQ-010 enable  input  1  permits a new packet to start.
REQ-011 out_data  output  32  packet word; byte 0 is [7:0] and is transmitted first.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  the sink accepts the word this cycle.
REQ-014 out_strb  output  4  valid-byte mask for out_data.
REQ-015 out_sop / out_eop  output  1 each  marks the first / last word of a packet.
REQ-016 busy  output  1  the FSM is not in IDLE.
REQ-017 underrun  output  1  sticky flag: the FIFO was empty during PAYLOAD.

Function
REQ-018 FSM states: IDLE, HEADER, PAYLOAD, FOOTER. The state is registered.
REQ-019 IDLE->HEADER occurs on a cycle with enable=1 and fifo_line_ready=1. Otherwise the FSM stays in IDLE with out_valid=0.
REQ-020 HEADER drives out_valid=1, out_sop=1 and out_strb=4'hF. out_data is {ECC, WC[15:8], WC[7:0], DI} with WC=LINE_BYTES.
REQ-021 ECC is the DSI 6-bit Hamming code over the 24 bits {WC, DI}; bits [7:6] of the ECC byte are 0.
REQ-022 HEADER->PAYLOAD occurs on out_ready. The word counter loads 0 and the CRC loads 16'hFFFF.
REQ-023 In PAYLOAD: out_data=fifo_data; out_valid=fifo_not_empty; out_strb=4'hF; fifo_read_ack=out_valid&out_ready.
REQ-024 Each word accepted in PAYLOAD increments the word counter. When the word accepted is number LINE_BYTES/4, the FSM goes to FOOTER on the next cycle.
REQ-025 The FSM never issues fifo_read_ack outside PAYLOAD and never pops more than LINE_BYTES/4 words per packet.
REQ-026 FOOTER drives out_valid=1, out_eop=1, out_strb=4'b0011 and out_data={16'h0000, CRC}, with the CRC low byte in [7:0].
REQ-027 FOOTER->IDLE occurs on out_ready. Back-to-back packets therefore have at least one IDLE cycle between them.
REQ-028 While out_valid=1 and out_ready=0, out_data, out_strb, out_sop and out_eop hold stable. A valid word is never withdrawn.
REQ-029 If fifo_not_empty=0 in PAYLOAD, the block stalls with out_valid=0 and sets underrun=1.
REQ-030 underrun clears only on the IDLE->HEADER transition; a new underrun in the same cycle wins.
REQ-031 Deasserting enable mid-packet has no effect; the packet completes. enable is sampled only in IDLE.
REQ-032 Outputs other than those stated are 0. out_sop and out_eop are never both 1 on the same word.
REQ-033 busy=1 in HEADER, PAYLOAD and FOOTER.

Reset
REQ-034 While rst_n=0: state=IDLE; out_valid, out_sop, out_eop, fifo_read_ack, busy and underrun are 0; out_data=0; out_strb=0; word counter=0; CRC=16'hFFFF.
REQ-035 A reset asserted mid-packet abandons the packet immediately. No partial footer is emitted after reset release.

Configuration
REQ-036 Macro DSI_TX_CRC_EN.
- Defined: the CRC is CRC-16-CCITT (polynomial x^16+x^12+x^5+1, init 16'hFFFF, no final XOR). It processes data LSB-first, bytes 0..3 of each accepted payload word in order, 4 bytes per cycle.
- Undefined: no CRC logic is synthesized and the footer CRC field is 16'h0000, the DSI "checksum not computed" value.

Verification
REQ-037 LINE_BYTES=640, DATA_TYPE=6'h3E, VC=0, FIFO preloaded with 160 words, out_ready=1, enable pulsed -> 162 words: header with [23:0]=24'h02803E and ECC matching the model, 160 payload words equal to the FIFO data, then the footer with eop; exactly 160 fifo_read_ack pulses.
REQ-038 DSI_TX_CRC_EN defined, LINE_BYTES=4, payload 32'h00000000 -> footer CRC equals the model value. With the macro undefined, the same stimulus gives footer out_data=32'h00000000 and strb=4'b0011.
REQ-039 out_ready toggled pseudo-randomly at 50% -> every word held stable while stalled; output word sequence identical to the out_ready=1 run.
REQ-040 fifo_not_empty forced to 0 for 5 cycles after payload word 10 -> out_valid=0 for those cycles; underrun=1 until the next packet's IDLE->HEADER; the remaining words are still delivered.
REQ-041 rst_n asserted at payload word 50, then released with enable=1 and line_ready=1 -> outputs zero during reset; the next packet starts with a header (sop); no footer is emitted before that header.
